// File: rtl/demux_14_tdm_pkg.sv
// Shared constants for the 4-slot TDM demultiplexer: FSM state encodings,
// the slot count and the slot index values.
package demux_14_tdm_pkg;
   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_e;

   localparam int         SLOTS = 4;
   localparam logic [1:0] SLOT0 = 2'd0;
   localparam logic [1:0] SLOT1 = 2'd1;
   localparam logic [1:0] SLOT2 = 2'd2;
   localparam logic [1:0] SLOT3 = 2'd3;
endpackage

// File: rtl/demux_slot_cnt.sv
// 2-bit slot index counter. Priority: reset, clear, load-1, increment (wraps 3 -> 0).
module demux_slot_cnt
   import demux_14_tdm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load1,
   input  logic       inc,
   output logic [1:0] cnt_q
);
   logic [1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = SLOT0;
      else if (load1)
         cnt_d = SLOT1;
      else if (inc)
         cnt_d = cnt_q + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= SLOT0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/demux_14_tdm.sv
// 1:4 time-division demultiplexer with HUNT/LOCK frame alignment. Slots 0..2 are
// staged; the whole frame is published together when slot 3 arrives.
module demux_14_tdm
   import demux_14_tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         en,
   input  logic         sync,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic [W-1:0] d,
   output logic         s1,
   output logic         s0,
   output logic         frame_valid,
   output logic         sync_err,
   output logic         locked
);
   state_e         state_q, state_d;
   logic [W-1:0]   stage_a_q, stage_a_d, stage_b_q, stage_b_d, stage_c_q, stage_c_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic           fv_q, fv_d, err_q, err_d;
   logic           cnt_clr, cnt_load1, cnt_inc;
   logic [1:0]     cnt_q;

   demux_slot_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .cnt_q (cnt_q)
   );

   always_comb begin
      state_d   = state_q;
      stage_a_d = stage_a_q;
      stage_b_d = stage_b_q;
      stage_c_d = stage_c_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      fv_d      = 1'b0;
      err_d     = 1'b0;
      cnt_clr   = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;
      if (en) begin
         if (sync) begin
            // A frame marker always restarts slot 0; only mid-frame in LOCK is it an error.
            stage_a_d = din;
            cnt_load1 = 1'b1;
            state_d   = LOCK;
            err_d     = (state_q == LOCK) && (cnt_q != SLOT0);
         end else if (state_q == LOCK) begin
            unique case (cnt_q)
               SLOT0: begin
                  err_d   = 1'b1;
                  cnt_clr = 1'b1;
                  state_d = HUNT;
               end
               SLOT1: begin
                  stage_b_d = din;
                  cnt_inc   = 1'b1;
               end
               SLOT2: begin
                  stage_c_d = din;
                  cnt_inc   = 1'b1;
               end
               default: begin
                  a_d     = stage_a_q;
                  b_d     = stage_b_q;
                  c_d     = stage_c_q;
                  d_d     = din;
                  fv_d    = 1'b1;
                  cnt_inc = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT;
         stage_a_q <= '0;
         stage_b_q <= '0;
         stage_c_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         fv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_a_q <= stage_a_d;
         stage_b_q <= stage_b_d;
         stage_c_q <= stage_c_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         d_q       <= d_d;
         fv_q      <= fv_d;
         err_q     <= err_d;
      end
   end

   assign a           = a_q;
   assign b           = b_q;
   assign c           = c_q;
   assign d           = d_q;
   assign s1          = cnt_q[1];
   assign s0          = cnt_q[0];
   assign frame_valid = fv_q;
   assign sync_err    = err_q;
   assign locked      = (state_q == LOCK);
endmodule

// File: tb/tb_demux_14_tdm.sv
// Directed bench for demux_14_tdm: framing, back-to-back frames, hunt, re-align,
// resync loss, reset mid-frame and en=0 gaps.
module tb_demux_14_tdm;
   localparam int W = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         en = 1'b0;
   logic         sync = 1'b0;
   logic [W-1:0] a, b, c, d;
   logic         s1, s0, frame_valid, sync_err, locked;

   int checks = 0;
   int errors = 0;
   int fv_count = 0;

   demux_14_tdm #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .en          (en),
      .sync        (sync),
      .a           (a),
      .b           (b),
      .c           (c),
      .d           (d),
      .s1          (s1),
      .s0          (s0),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic r, input logic e, input logic s, input logic [W-1:0] v);
      @(negedge clk);
      rst  = r;
      en   = e;
      sync = s;
      din  = v;
      @(posedge clk);
      #1;
      if (frame_valid) fv_count++;
      chk("fv_err_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
   endtask

   // Checks a..d packed as {a,b,c,d}, the slot index, and the three status bits.
   task automatic chk_all(input string tag, input logic [3:0] abcd, input logic [1:0] slot,
                          input logic fv, input logic err, input logic lk);
      chk({tag, "_abcd"}, {28'd0, a, b, c, d}, {28'd0, abcd});
      chk({tag, "_slot"}, {30'd0, s1, s0}, {30'd0, slot});
      chk({tag, "_fv"}, {31'd0, frame_valid}, {31'd0, fv});
      chk({tag, "_err"}, {31'd0, sync_err}, {31'd0, err});
      chk({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
   endtask

   int fv_base;

   initial begin
      // Reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk_all("reset", 4'b0000, 2'd0, 0, 0, 0);

      // Frame 1,0,0,0
      step(0, 1, 1, 1);
      chk_all("f1_s0", 4'b0000, 2'd1, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk_all("f1_s2", 4'b0000, 2'd3, 0, 0, 1);
      step(0, 1, 0, 0);
      chk_all("f1_done", 4'b1000, 2'd0, 1, 0, 1);
      step(0, 0, 0, 0);
      chk_all("f1_idle", 4'b1000, 2'd0, 0, 0, 1);

      // Back-to-back frames 0,1,0,0 and 0,0,1,1
      fv_base = fv_count;
      step(0, 1, 1, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk_all("f2_done", 4'b0100, 2'd0, 1, 0, 1);
      step(0, 1, 1, 0);
      chk_all("f3_s0", 4'b0100, 2'd1, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      chk_all("f3_done", 4'b0011, 2'd0, 1, 0, 1);
      chk("b2b_pulses", fv_count - fv_base, 2);

      // sync=0 where slot 0 expected: lose lock
      step(0, 1, 0, 1);
      chk_all("lost", 4'b0011, 2'd0, 0, 1, 0);

      // Reset, then hunt with sync=0 only
      step(1, 1, 1, 1);
      chk_all("reset_prio", 4'b0000, 2'd0, 0, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      chk_all("hunt", 4'b0000, 2'd0, 0, 0, 0);
      step(0, 1, 1, 1);
      chk_all("hunt_sync", 4'b0000, 2'd1, 0, 0, 1);

      // sync on slot 2 mid-frame: re-align
      step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      chk_all("realign", 4'b0000, 2'd1, 0, 1, 1);
      step(0, 1, 0, 1);
      chk_all("realign_s1", 4'b0000, 2'd2, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      chk_all("realign_done", 4'b1101, 2'd0, 1, 0, 1);

      // Reset after slot 2 of a partial frame
      step(0, 1, 1, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      fv_base = fv_count;
      step(1, 1, 0, 1);
      chk_all("rst_mid", 4'b0000, 2'd0, 0, 0, 0);
      chk("rst_mid_nofv", fv_count - fv_base, 0);

      // Gapped frame 1,0,1,1 with en=0 holes (sync=1 during a hole is ignored)
      step(0, 1, 1, 1);
      step(0, 0, 0, 0);
      chk_all("gap1", 4'b0000, 2'd1, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      chk_all("gap2", 4'b0000, 2'd2, 0, 0, 1);
      step(0, 1, 0, 1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 1);
      chk_all("gap_done", 4'b1011, 2'd0, 1, 0, 1);
      step(0, 0, 0, 0);
      chk_all("gap_after", 4'b1011, 2'd0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
